lock_ctrl: RTL
==============

// Module: lock_ctrl
// PURPOSE
//  Sequencer in front of the `lock` datapath. Takes debounced one-cycle button pulses, counts digits,
//  forwards them to the lock as l_b0/l_b1/l_enter/l_reset, and judges the verdict on lock_locked.
//  Adds attempt limiting with a tick-timed lockout, an entry inactivity timeout, and code reprogramming
//  while open. Owns the code register that drives the lock's code input.
// PARAMETERS
//  CODE_SIZE      8      digits per code; width of code_out
//  CODE_INIT      0      code_reg value loaded at reset (CODE_SIZE bits)
//  MAX_FAILS      3      consecutive failed attempts that trigger LOCKOUT (>=1)
//  LOCKOUT_TICKS  16     tick pulses spent in LOCKOUT (>=1)
//  IDLE_TICKS     32     ticks with no digit before ENTRY/PROG/OPEN times out (>=1)
// PORTS
//  clk          in   1          system clock
//  reset_n      in   1          synchronous reset, active low
//  tick         in   1          one-clk pulse from the slow clock divider, synchronous to clk
//  b0, b1       in   1          digit pulses, one clk wide
//  enter        in   1          submit pulse
//  prog         in   1          enter-program-mode pulse (honoured only in OPEN)
//  lock_locked  in   1          `out` of the lock datapath
//  l_b0, l_b1   out  1          digit pulses to the lock
//  l_enter      out  1          enter pulse to the lock
//  l_reset      out  1          reset pulse to the lock
//  code_out     out  CODE_SIZE  current code, to the lock's code input
//  unlocked     out  1          1 while in OPEN or PROG
//  lockout      out  1          1 while in LOCKOUT
//  fail_cnt     out  clog2(MAX_FAILS+1)  consecutive failures
//  state        out  3          IDLE=0 ENTRY=1 CHECK=2 OPEN=3 PROG=4 LOCKOUT=5
// BEHAVIOUR
//  - All outputs registered. Reset (reset_n=0 at edge): state=IDLE, fail_cnt=0, code_reg=CODE_INIT,
//    unlocked=0, lockout=0, l_b0=l_b1=l_enter=0, l_reset=1 (clears lock on first cycle after reset),
//    digit_cnt=0, timers=0. Reset mid-operation aborts everything; code_reg returns to CODE_INIT.
//  - Every l_* output is a one-cycle pulse issued on the clk after the causing input (latency 1).
//  - Same-cycle inputs: enter > b0 > b1 > prog; lower-priority pulses in that cycle are dropped.
//  - IDLE/ENTRY: b0/b1 -> forward, digit_cnt++, idle timer cleared, state=ENTRY. Digits beyond
//    CODE_SIZE are dropped (not forwarded, no counter wrap).
//    enter with digit_cnt==CODE_SIZE -> l_enter, go CHECK. enter with 0<digit_cnt<CODE_SIZE -> counted
//    as failure (same as mismatch), l_reset. enter with digit_cnt==0 in IDLE -> ignored.
//  - CHECK: all buttons ignored. lock_locked is sampled exactly 3 clk after the enter edge (lock registers
//    the verdict 1 clk after l_enter). 0 -> OPEN, fail_cnt=0. 1 -> fail_cnt++; if it reaches MAX_FAILS ->
//    LOCKOUT (timer=LOCKOUT_TICKS), else IDLE. digit_cnt cleared either way.
//  - OPEN: unlocked=1. enter -> l_reset, IDLE. prog -> PROG, digit_cnt=0. Digits ignored.
//  - PROG: unlocked=1; b0/b1 shift into new_code LSB-first-in ({new_code,bit}), digit_cnt++, never forwarded.
//    enter with digit_cnt==CODE_SIZE -> code_reg<=new_code, OPEN. enter short -> discard, OPEN, code kept.
//  - Timeout: in ENTRY, PROG, OPEN count ticks since last digit/entry; at IDLE_TICKS -> ENTRY: l_reset,
//    IDLE, no failure; PROG: discard, OPEN; OPEN: l_reset, IDLE (auto-relock). Tick and digit same cycle:
//    digit wins, timer cleared.
//  - LOCKOUT: lockout=1; all buttons ignored; timer decrements per tick; at 0 -> IDLE, fail_cnt=0, l_reset.
// TESTING  (CODE_SIZE=4, CODE_INIT=4'b1010, MAX_FAILS=3, LOCKOUT_TICKS=4, IDLE_TICKS=8, real lock attached)
//  - Reset, then b1,b0,b1,b0,enter -> 4 forwarded pulses, CHECK, OPEN 3 clk after enter, unlocked=1, fail_cnt=0.
//  - Wrong code 1111+enter three times -> fail_cnt 1,2 then LOCKOUT; digits ignored; 4 ticks -> IDLE, fail_cnt=0.
//  - Short entry b1,enter -> failure counted, l_reset pulsed, state IDLE; 5th digit after 4 not forwarded.
//  - OPEN, prog, b0,b1,b1,b0,enter -> code_out=4'b0110; enter relocks; 0110+enter opens, 1010 fails.
//  - ENTRY with 2 digits then 8 ticks idle -> l_reset, IDLE, fail_cnt unchanged; enter+b0 same cycle -> b0 dropped.
//  - reset_n low in LOCKOUT and in PROG -> next cycle IDLE, lockout=0, code_out=CODE_INIT, l_reset=1.

Source files
------------

// File: rtl/lock_ctrl.sv
// Purpose  : sequencer in front of the lock datapath; counts digits, forwards pulses, judges the
//            verdict, limits attempts with a tick-timed lockout, times out idle entry, reprograms code.
// Latency  : every output registered; l_* pulses appear 1 clk after the causing input.
// Backpress: none; at most one button per cycle is honoured (enter > b0 > b1 > prog), others dropped.
// Ports    : clk, reset_n (sync, active low), tick (slow divider pulse), b0/b1/enter/prog (button
//            pulses), lock_locked (lock verdict) -> l_b0/l_b1/l_enter/l_reset (to lock), code_out,
//            unlocked, lockout, fail_cnt, state.
module lock_ctrl #(
   parameter int                   CODE_SIZE     = 8,
   parameter logic [CODE_SIZE-1:0] CODE_INIT     = '0,
   parameter int                   MAX_FAILS     = 3,
   parameter int                   LOCKOUT_TICKS = 16,
   parameter int                   IDLE_TICKS    = 32,
   localparam int                  FW            = $clog2(MAX_FAILS + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic                 b0,
   input  logic                 b1,
   input  logic                 enter,
   input  logic                 prog,
   input  logic                 lock_locked,
   output logic                 l_b0,
   output logic                 l_b1,
   output logic                 l_enter,
   output logic                 l_reset,
   output logic [CODE_SIZE-1:0] code_out,
   output logic                 unlocked,
   output logic                 lockout,
   output logic [FW-1:0]        fail_cnt,
   output logic [2:0]           state
);
   localparam int DW = $clog2(CODE_SIZE + 1);
   localparam int IW = $clog2(IDLE_TICKS + 1);
   localparam int LW = $clog2(LOCKOUT_TICKS + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_PROG    = 3'd4,
      S_LOCKOUT = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [FW-1:0]        fail_q, fail_d;
   logic [CODE_SIZE-1:0] code_q, code_d;
   logic [CODE_SIZE-1:0] new_code_q, new_code_d;
   logic [DW-1:0]        digit_cnt_q, digit_cnt_d;
   logic [IW-1:0]        idle_q, idle_d;
   logic [LW-1:0]        lo_q, lo_d;
   logic [1:0]           chk_q, chk_d;
   logic                 l_b0_q, l_b0_d, l_b1_q, l_b1_d;
   logic                 l_enter_q, l_enter_d, l_reset_q, l_reset_d;
   logic                 unlocked_q, unlocked_d, lockout_q, lockout_d;

   // single winning button per cycle
   logic ev_enter, ev_b0, ev_b1, ev_prog, ev_digit;
   logic idle_to;
   logic [FW-1:0] fail_inc;
   logic to_lockout;

   always_comb begin
      ev_enter   = enter;
      ev_b0      = !enter && b0;
      ev_b1      = !enter && !b0 && b1;
      ev_prog    = !enter && !b0 && !b1 && prog;
      ev_digit   = ev_b0 || ev_b1;
      idle_to    = tick && (idle_q == IW'(IDLE_TICKS - 1));
      fail_inc   = fail_q + 1'b1;
      to_lockout = (fail_inc == FW'(MAX_FAILS));

      state_d     = state_q;
      fail_d      = fail_q;
      code_d      = code_q;
      new_code_d  = new_code_q;
      digit_cnt_d = digit_cnt_q;
      idle_d      = idle_q;
      lo_d        = lo_q;
      chk_d       = chk_q;
      l_b0_d      = 1'b0;
      l_b1_d      = 1'b0;
      l_enter_d   = 1'b0;
      l_reset_d   = 1'b0;

      case (state_q)
         S_IDLE, S_ENTRY: begin
            if (ev_enter) begin
               if (digit_cnt_q == DW'(CODE_SIZE)) begin
                  l_enter_d = 1'b1;
                  state_d   = S_CHECK;
                  chk_d     = '0;
                  idle_d    = '0;
               end else if (digit_cnt_q != '0) begin
                  // short entry is judged as a failed attempt without involving the lock
                  l_reset_d   = 1'b1;
                  digit_cnt_d = '0;
                  idle_d      = '0;
                  fail_d      = fail_inc;
                  if (to_lockout) begin
                     state_d = S_LOCKOUT;
                     lo_d    = LW'(LOCKOUT_TICKS);
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else if (ev_digit && digit_cnt_q != DW'(CODE_SIZE)) begin
               l_b0_d      = ev_b0;
               l_b1_d      = ev_b1;
               digit_cnt_d = digit_cnt_q + 1'b1;
               idle_d      = '0;
               state_d     = S_ENTRY;
            end else if (state_q == S_ENTRY && tick) begin
               // a dropped surplus digit does not restart the inactivity timer
               if (idle_to) begin
                  l_reset_d   = 1'b1;
                  state_d     = S_IDLE;
                  digit_cnt_d = '0;
                  idle_d      = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end
         S_CHECK: begin
            // lock registers its verdict one clk after l_enter; sample on the third clk after enter
            if (chk_q == 2'd2) begin
               digit_cnt_d = '0;
               if (!lock_locked) begin
                  state_d = S_OPEN;
                  fail_d  = '0;
                  idle_d  = '0;
               end else begin
                  fail_d = fail_inc;
                  if (to_lockout) begin
                     state_d = S_LOCKOUT;
                     lo_d    = LW'(LOCKOUT_TICKS);
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else begin
               chk_d = chk_q + 1'b1;
            end
         end
         S_OPEN: begin
            if (ev_enter) begin
               l_reset_d = 1'b1;
               state_d   = S_IDLE;
               idle_d    = '0;
            end else if (ev_prog) begin
               state_d     = S_PROG;
               digit_cnt_d = '0;
               new_code_d  = '0;
               idle_d      = '0;
            end else if (tick) begin
               if (idle_to) begin
                  l_reset_d = 1'b1;
                  state_d   = S_IDLE;
                  idle_d    = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end
         S_PROG: begin
            if (ev_enter) begin
               if (digit_cnt_q == DW'(CODE_SIZE)) code_d = new_code_q;
               state_d     = S_OPEN;
               digit_cnt_d = '0;
               idle_d      = '0;
            end else if (ev_digit) begin
               // over-long entry keeps the most recent CODE_SIZE digits
               new_code_d = CODE_SIZE'({new_code_q, ev_b1});
               if (digit_cnt_q != DW'(CODE_SIZE)) digit_cnt_d = digit_cnt_q + 1'b1;
               idle_d = '0;
            end else if (tick) begin
               if (idle_to) begin
                  state_d     = S_OPEN;
                  digit_cnt_d = '0;
                  idle_d      = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end
         S_LOCKOUT: begin
            if (tick) begin
               if (lo_q == LW'(1)) begin
                  state_d   = S_IDLE;
                  fail_d    = '0;
                  l_reset_d = 1'b1;
                  lo_d      = '0;
               end else begin
                  lo_d = lo_q - 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      unlocked_d = (state_d == S_OPEN) || (state_d == S_PROG);
      lockout_d  = (state_d == S_LOCKOUT);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         fail_q      <= '0;
         code_q      <= CODE_INIT;
         new_code_q  <= '0;
         digit_cnt_q <= '0;
         idle_q      <= '0;
         lo_q        <= '0;
         chk_q       <= '0;
         l_b0_q      <= 1'b0;
         l_b1_q      <= 1'b0;
         l_enter_q   <= 1'b0;
         l_reset_q   <= 1'b1;
         unlocked_q  <= 1'b0;
         lockout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         fail_q      <= fail_d;
         code_q      <= code_d;
         new_code_q  <= new_code_d;
         digit_cnt_q <= digit_cnt_d;
         idle_q      <= idle_d;
         lo_q        <= lo_d;
         chk_q       <= chk_d;
         l_b0_q      <= l_b0_d;
         l_b1_q      <= l_b1_d;
         l_enter_q   <= l_enter_d;
         l_reset_q   <= l_reset_d;
         unlocked_q  <= unlocked_d;
         lockout_q   <= lockout_d;
      end
   end

   assign l_b0     = l_b0_q;
   assign l_b1     = l_b1_q;
   assign l_enter  = l_enter_q;
   assign l_reset  = l_reset_q;
   assign code_out = code_q;
   assign unlocked = unlocked_q;
   assign lockout  = lockout_q;
   assign fail_cnt = fail_q;
   assign state    = state_q;

endmodule
